// File: rtl/adc_frame_tx.sv
// adc_frame_tx: packet buffer and framer between an ADC packetiser and a byte-wide host link.
// Incoming packets are written speculatively into a payload FIFO and become visible to the
// read side only when their last byte commits them. Each committed packet is sent as
//   SYNC_WORD[15:8], SYNC_WORD[7:0], LEN, payload[0..N-1] [, CSUM]
// where LEN is the byte count (256 encoded as 0).
// Optional feature macro: ADC_FRAME_CHECKSUM_EN (adds the trailing modulo-256 checksum byte
// covering LEN and the payload).
module adc_frame_tx #(
    parameter int unsigned FIFO_AW   = 9,
    parameter int unsigned LEN_DEPTH = 8,
    parameter logic [15:0] SYNC_WORD = 16'h55AA
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_adc_len,
    input  logic [7:0]  i_adc_data,
    input  logic        i_adc_last,
    input  logic        i_adc_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_overflow,
    output logic [15:0] o_drop_cnt
);

    localparam int unsigned LQ_AW = (LEN_DEPTH > 1) ? $clog2(LEN_DEPTH) : 1;
    localparam int unsigned LQ_CW = $clog2(LEN_DEPTH + 1);

`ifdef ADC_FRAME_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StHdr0, StHdr1, StLen, StPay, StCsum} state_e;
`else
    typedef enum logic [2:0] {StIdle, StHdr0, StHdr1, StLen, StPay} state_e;
`endif

    // Payload storage and pointers (extra MSB separates full from empty)
    logic [7:0]         r_mem [2**FIFO_AW];
    logic [FIFO_AW:0]   r_wr_spec;
    logic [FIFO_AW:0]   r_wr_commit;
    logic [FIFO_AW:0]   r_rd_ptr;

    // Write-side packet tracking
    logic [8:0]         r_byte_cnt;
    logic               r_discard;
    logic               r_overflow;
    logic [15:0]        r_drop_cnt;

    // Length queue
    logic [7:0]         r_lq [LEN_DEPTH];
    logic [LQ_AW-1:0]   r_lq_wr;
    logic [LQ_AW-1:0]   r_lq_rd;
    logic [LQ_CW-1:0]   r_lq_cnt;

    // Read-side framer
    state_e             r_state;
    logic [7:0]         r_tx_data;
    logic               r_tx_valid;
    logic [7:0]         r_len;
    logic [8:0]         r_rem;
`ifdef ADC_FRAME_CHECKSUM_EN
    logic [7:0]         r_csum;
`endif

    logic [FIFO_AW:0]   w_fifo_used;
    logic               w_fifo_full;
    logic               w_lq_full;
    logic               w_byte;
    logic               w_drop;
    logic               w_wr_en;
    logic               w_push;
    logic [FIFO_AW:0]   w_spec_inc;
    logic [8:0]         w_cnt_inc;
    logic               w_hs;
    logic               w_frame_done;
    logic [7:0]         w_lq_head;
    logic               w_unused;

    // Declared length is informational only
    assign w_unused = ^i_adc_len;

    // Write-side admission: drop on full FIFO, full length queue at commit, or byte 257
    always_comb begin
        w_fifo_used = r_wr_spec - r_rd_ptr;
        w_fifo_full = w_fifo_used[FIFO_AW];
        w_lq_full   = (r_lq_cnt == LQ_CW'(LEN_DEPTH));
        w_byte      = i_adc_valid && !r_discard;
        w_drop      = w_byte && (w_fifo_full || r_byte_cnt[8] || (i_adc_last && w_lq_full));
        w_wr_en     = w_byte && !w_drop;
        w_push      = w_wr_en && i_adc_last;
        w_spec_inc  = r_wr_spec + 1'b1;
        w_cnt_inc   = r_byte_cnt + 9'd1;
        w_hs        = r_tx_valid && i_tx_ready;
        w_lq_head   = r_lq[r_lq_rd];
`ifdef ADC_FRAME_CHECKSUM_EN
        w_frame_done = w_hs && (r_state == StCsum);
`else
        w_frame_done = w_hs && (r_state == StPay) && (r_rem == 9'd1);
`endif
    end

    // Payload RAM write port
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_spec[FIFO_AW-1:0]] <= i_adc_data;
        end
    end

    // Speculative/committed write pointers, drop handling and drop statistics
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_spec   <= '0;
            r_wr_commit <= '0;
            r_byte_cnt  <= '0;
            r_discard   <= 1'b0;
            r_overflow  <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_overflow <= w_drop;
            if (w_drop) begin
                r_wr_spec  <= r_wr_commit;
                r_byte_cnt <= '0;
                // Swallow the rest of the packet unless this byte already ended it
                r_discard  <= !i_adc_last;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end else if (w_wr_en) begin
                r_wr_spec <= w_spec_inc;
                if (i_adc_last) begin
                    r_wr_commit <= w_spec_inc;
                    r_byte_cnt  <= '0;
                end else begin
                    r_byte_cnt <= w_cnt_inc;
                end
            end else if (i_adc_valid && r_discard && i_adc_last) begin
                r_discard <= 1'b0;
            end
        end
    end

    // Length queue: entry is released only when its frame completes, so the frame in
    // flight still occupies a slot and LEN_DEPTH bounds all committed, unfinished packets
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_lq_wr  <= '0;
            r_lq_rd  <= '0;
            r_lq_cnt <= '0;
            for (int i = 0; i < LEN_DEPTH; i++) begin
                r_lq[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_lq[r_lq_wr] <= w_cnt_inc[7:0];
                r_lq_wr <= (r_lq_wr == LQ_AW'(LEN_DEPTH - 1)) ? '0 : r_lq_wr + 1'b1;
            end
            if (w_frame_done) begin
                r_lq_rd <= (r_lq_rd == LQ_AW'(LEN_DEPTH - 1)) ? '0 : r_lq_rd + 1'b1;
            end
            if (w_push && !w_frame_done) begin
                r_lq_cnt <= r_lq_cnt + 1'b1;
            end else if (!w_push && w_frame_done) begin
                r_lq_cnt <= r_lq_cnt - 1'b1;
            end
        end
    end

    // Framer FSM with registered byte/valid outputs; advances only on handshake
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= StIdle;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_rd_ptr   <= '0;
            r_len      <= '0;
            r_rem      <= '0;
`ifdef ADC_FRAME_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (r_lq_cnt != '0) begin
                        r_len      <= w_lq_head;
                        r_rem      <= (w_lq_head == 8'd0) ? 9'd256 : {1'b0, w_lq_head};
                        r_tx_data  <= SYNC_WORD[15:8];
                        r_tx_valid <= 1'b1;
                        r_state    <= StHdr0;
`ifdef ADC_FRAME_CHECKSUM_EN
                        r_csum     <= '0;
`endif
                    end
                end
                StHdr0: begin
                    if (w_hs) begin
                        r_tx_data <= SYNC_WORD[7:0];
                        r_state   <= StHdr1;
                    end
                end
                StHdr1: begin
                    if (w_hs) begin
                        r_tx_data <= r_len;
                        r_state   <= StLen;
                    end
                end
                StLen: begin
                    if (w_hs) begin
                        r_tx_data <= r_mem[r_rd_ptr[FIFO_AW-1:0]];
                        r_rd_ptr  <= r_rd_ptr + 1'b1;
                        r_state   <= StPay;
`ifdef ADC_FRAME_CHECKSUM_EN
                        r_csum    <= r_csum + r_len;
`endif
                    end
                end
                StPay: begin
                    if (w_hs) begin
`ifdef ADC_FRAME_CHECKSUM_EN
                        r_csum <= r_csum + r_tx_data;
`endif
                        if (r_rem == 9'd1) begin
`ifdef ADC_FRAME_CHECKSUM_EN
                            r_tx_data  <= r_csum + r_tx_data;
                            r_state    <= StCsum;
`else
                            r_tx_data  <= '0;
                            r_tx_valid <= 1'b0;
                            r_state    <= StIdle;
`endif
                        end else begin
                            r_tx_data <= r_mem[r_rd_ptr[FIFO_AW-1:0]];
                            r_rd_ptr  <= r_rd_ptr + 1'b1;
                            r_rem     <= r_rem - 9'd1;
                        end
                    end
                end
`ifdef ADC_FRAME_CHECKSUM_EN
                StCsum: begin
                    if (w_hs) begin
                        r_tx_data  <= '0;
                        r_tx_valid <= 1'b0;
                        r_state    <= StIdle;
                    end
                end
`endif
                default: begin
                    r_state    <= StIdle;
                    r_tx_valid <= 1'b0;
                    r_tx_data  <= '0;
                end
            endcase
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_overflow = r_overflow;
    assign o_drop_cnt = r_drop_cnt;

endmodule
